// File: rtl/var_seq_cu.sv
// var_seq_cu: multi-cycle control unit sequencing IF/IR/ID/EX/MEM/WB/BR with variable memory latency
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   run               permits instruction fetch (stalls only in IF)
//   inst_ready        instruction memory data valid
//   mem_ready         data memory access complete
//   opcode            instruction opcode from IR, low TYPE_BITS bits select the type
//   BEQout            branch comparison result, sampled in BR
//   InstRead..ldPC    datapath control strobes
//   S                 one-hot state {IF,IR,ID,EX,MEM,WB,BR}, bit 0 = IF
//   T                 one-hot registered instruction type, zero until first decode
//   illegal           one-cycle pulse after decoding an undefined type
//   retired           count of completed instructions (wraps)
module var_seq_cu #(
    parameter int OPW       = 6,
    parameter int TYPE_BITS = 3,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    inst_ready,
    input  logic                    mem_ready,
    input  logic [OPW-1:0]          opcode,
    input  logic                    BEQout,
    output logic                    InstRead,
    output logic                    ldIR,
    output logic                    RegRead,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    RegWrite,
    output logic                    incPC,
    output logic                    ldPC,
    output logic [6:0]              S,
    output logic [2**TYPE_BITS-1:0] T,
    output logic                    illegal,
    output logic [CNT_W-1:0]        retired
);
    localparam int NT = 2**TYPE_BITS;
    typedef enum logic [2:0] {S_IF, S_IR, S_ID, S_EX, S_MEM, S_WB, S_BR} state_t;
    state_t state, state_nx;
    logic [TYPE_BITS-1:0] ty;
    logic undef, retire;
    assign ty = opcode[TYPE_BITS-1:0];
    // Only the wider decode has type codes beyond beq (7)
    generate
        if (TYPE_BITS > 3) begin : g_wide
            assign undef = |ty[TYPE_BITS-1:3];
        end else begin : g_narrow
            assign undef = 1'b0;
        end
    endgenerate
    always_comb begin
        state_nx = state;
        case (state)
            S_IF:    state_nx = (run && inst_ready) ? S_IR : S_IF;
            S_IR:    state_nx = S_ID;
            S_ID:    state_nx = (ty == '0 || undef) ? S_WB : S_EX;
            S_EX:    state_nx = (T[5] || T[6]) ? S_MEM : S_WB;
            S_MEM:   state_nx = mem_ready ? S_WB : S_MEM;
            S_WB:    state_nx = T[7] ? S_BR : S_IF;
            default: state_nx = S_IF;
        endcase
    end
    assign S = 7'b1 << state;
    // InstRead is gated by rst_n since IF is also the reset state
    assign InstRead = rst_n && run && state == S_IF;
    assign ldIR     = state == S_IR;
    assign RegRead  = state == S_ID;
    assign MemRead  = state == S_MEM && T[5];
    assign MemWrite = state == S_MEM && T[6];
    assign RegWrite = state == S_WB && |T[5:1];
    assign incPC    = state == S_WB;
    assign ldPC     = state == S_BR && BEQout;
    assign retire   = (state == S_WB && !T[7]) || state == S_BR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IF;
            T       <= '0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_nx;
            illegal <= state == S_ID && undef;
            if (state == S_ID) T <= NT'(1) << ty;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_var_seq_cu.sv
// tb_var_seq_cu: table-driven and directed checks of the var_seq_cu control unit
module tb_var_seq_cu;
    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, inst_ready = 1'b0, mem_ready = 1'b0, BEQout = 1'b0;
    logic [5:0] opcode = '0;
    logic InstRead, ldIR, RegRead, MemRead, MemWrite, RegWrite, incPC, ldPC, illegal;
    logic [6:0] S;
    logic [15:0] T, retired;
    logic w_InstRead, w_ldIR, w_RegRead, w_MemRead, w_MemWrite, w_RegWrite, w_incPC, w_ldPC, w_illegal;
    logic [6:0] w_S;
    logic [7:0] w_T;
    logic [1:0] w_retired;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    var_seq_cu #(.OPW(6), .TYPE_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_ready(inst_ready), .mem_ready(mem_ready),
        .opcode(opcode), .BEQout(BEQout), .InstRead(InstRead), .ldIR(ldIR), .RegRead(RegRead),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .incPC(incPC), .ldPC(ldPC),
        .S(S), .T(T), .illegal(illegal), .retired(retired));

    var_seq_cu #(.OPW(6), .TYPE_BITS(3), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run), .inst_ready(inst_ready), .mem_ready(mem_ready),
        .opcode(opcode), .BEQout(BEQout), .InstRead(w_InstRead), .ldIR(w_ldIR), .RegRead(w_RegRead),
        .MemRead(w_MemRead), .MemWrite(w_MemWrite), .RegWrite(w_RegWrite), .incPC(w_incPC), .ldPC(w_ldPC),
        .S(w_S), .T(w_T), .illegal(w_illegal), .retired(w_retired));

    typedef struct {
        logic [5:0] op;
        int iw, wt;
        logic beq;
        int cyc;
        logic [6:0] mask;
        int rw, mr, mw, inc, ld, ill, ty;
    } vec_t;
    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {InstRead, ldIR, RegRead, MemRead, MemWrite, RegWrite, incPC, ldPC};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; inst_ready = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Run one instruction from IF until retired moves, counting strobes per cycle
    task automatic run_inst(input vec_t v, input int idx);
        int cyc = 0, ic = 0, mc = 0, rw = 0, mr = 0, mw = 0, inc = 0, ld = 0, ill = 0, bad = 0;
        logic [6:0] mask = '0;
        logic [15:0] r0 = retired;
        while (1) begin
            run = S[0];
            inst_ready = S[0] && ic >= v.iw;
            if (S[0]) ic++;
            mem_ready = S[4] && mc >= v.wt;
            if (S[4]) mc++;
            opcode = S[2] ? v.op : 6'($urandom);
            BEQout = S[6] ? v.beq : ~v.beq;
            #1;
            mask |= S;
            if ($countones(S) != 1) bad++;
            rw += int'(RegWrite); mr += int'(MemRead); mw += int'(MemWrite);
            inc += int'(incPC); ld += int'(ldPC); ill += int'(illegal);
            @(posedge clk); #1;
            cyc++;
            if (retired != r0 || cyc >= 40) break;
        end
        chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
        chk($sformatf("v%0d path", idx), 32'(mask), 32'(v.mask));
        chk($sformatf("v%0d onehot", idx), bad, 0);
        chk($sformatf("v%0d RegWrite", idx), rw, v.rw);
        chk($sformatf("v%0d MemRead", idx), mr, v.mr);
        chk($sformatf("v%0d MemWrite", idx), mw, v.mw);
        chk($sformatf("v%0d incPC", idx), inc, v.inc);
        chk($sformatf("v%0d ldPC", idx), ld, v.ld);
        chk($sformatf("v%0d illegal", idx), ill, v.ill);
        chk($sformatf("v%0d T", idx), 32'(T), 32'(16'(1) << v.ty));
        chk($sformatf("v%0d retired", idx), 32'(retired), 32'(r0 + 16'd1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_w[5];
        exp_w = '{1, 2, 3, 0, 1};
        //          op      iw wt beq  cyc mask   rw mr mw inc ld ill ty
        vt[0]  = '{6'd0,  0, 0, 1'b0, 4, 7'h27, 0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{6'd1,  0, 0, 1'b0, 5, 7'h2F, 1, 0, 0, 1, 0, 0, 1};
        vt[2]  = '{6'd2,  0, 0, 1'b0, 5, 7'h2F, 1, 0, 0, 1, 0, 0, 2};
        vt[3]  = '{6'd3,  0, 0, 1'b0, 5, 7'h2F, 1, 0, 0, 1, 0, 0, 3};
        vt[4]  = '{6'd4,  0, 0, 1'b0, 5, 7'h2F, 1, 0, 0, 1, 0, 0, 4};
        vt[5]  = '{6'd5,  0, 0, 1'b0, 6, 7'h3F, 1, 1, 0, 1, 0, 0, 5};
        vt[6]  = '{6'd5,  0, 3, 1'b0, 9, 7'h3F, 1, 4, 0, 1, 0, 0, 5};
        vt[7]  = '{6'd6,  0, 0, 1'b0, 6, 7'h3F, 0, 0, 1, 1, 0, 0, 6};
        vt[8]  = '{6'd6,  0, 2, 1'b0, 8, 7'h3F, 0, 0, 3, 1, 0, 0, 6};
        vt[9]  = '{6'd7,  0, 0, 1'b1, 6, 7'h6F, 0, 0, 0, 1, 1, 0, 7};
        vt[10] = '{6'd7,  0, 0, 1'b0, 6, 7'h6F, 0, 0, 0, 1, 0, 0, 7};
        vt[11] = '{6'd9,  0, 0, 1'b0, 4, 7'h27, 0, 0, 0, 1, 0, 1, 9};
        vt[12] = '{6'h31, 0, 0, 1'b0, 5, 7'h2F, 1, 0, 0, 1, 0, 0, 1};
        vt[13] = '{6'd15, 0, 0, 1'b0, 4, 7'h27, 0, 0, 0, 1, 0, 1, 15};
        vt[14] = '{6'd0,  2, 0, 1'b0, 6, 7'h27, 0, 0, 0, 1, 0, 0, 0};
        vt[15] = '{6'd8,  0, 0, 1'b0, 4, 7'h27, 0, 0, 0, 1, 0, 1, 8};

        run = 1'b1; inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst S", 32'(S), 32'h1);
        chk("rst T", 32'(T), 0);
        chk("rst retired", 32'(retired), 0);
        chk("rst illegal", 32'(illegal), 0);
        chk("rst controls", 32'(ctl()), 0);
        chk("rst retired_w", 32'(w_retired), 0);

        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("idle%0d S", k), 32'(S), 32'h1);
            chk($sformatf("idle%0d InstRead", k), 32'(InstRead), 0);
            chk($sformatf("idle%0d retired", k), 32'(retired), 0);
        end
        run = 1'b1; inst_ready = 1'b1; opcode = '0;
        #1;
        chk("fetch InstRead", 32'(InstRead), 1);
        @(posedge clk); #1;
        chk("fetch S", 32'(S), 32'h2);

        do_reset();
        for (int i = 0; i < 16; i++) run_inst(vt[i], i);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_inst(vt[0], 100 + k);
            chk($sformatf("wrap%0d retired_w", k), 32'(w_retired), 32'(exp_w[k]));
        end

        run = 1'b1; inst_ready = 1'b1; mem_ready = 1'b0; opcode = 6'd6;
        for (int k = 0; k < 10 && !S[4]; k++) begin
            @(posedge clk); #1;
        end
        chk("sw MEM reached", 32'(S), 32'h10);
        chk("sw MemWrite", 32'(MemWrite), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort MemWrite", 32'(MemWrite), 0);
        chk("abort S", 32'(S), 32'h1);
        chk("abort retired", 32'(retired), 0);
        chk("abort T", 32'(T), 0);
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held%0d controls", k), 32'(ctl()), 0);
            chk($sformatf("held%0d S", k), 32'(S), 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("resume S", 32'(S), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
